// File: rtl/uart_apb_bridge.sv
// APB3 completer that maps APB transfers onto the UART's single-cycle register-file port.
// Writes finish with zero wait states; reads take one wait state; illegal accesses return PSLVERR.
module uart_apb_bridge #(
    parameter int unsigned PADDR_W    = 12,
    parameter int unsigned NUM_REGS   = 8,
    parameter logic [4:0]  IDLE_RADDR = 5'h1F
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [PADDR_W-1:0] paddr_i,
    input  logic [31:0]        pwdata_i,
    input  logic [3:0]         pstrb_i,
    output logic               pready_o,
    output logic [31:0]        prdata_o,
    output logic               pslverr_o,
    output logic               reg_we_o,
    output logic [4:0]         reg_waddr_o,
    output logic [31:0]        reg_wdata_o,
    output logic [4:0]         reg_raddr_o,
    input  logic [31:0]        reg_rdata_i
);

    typedef enum logic {
        IDLE,
        RD_RESP
    } state_t;

    state_t state, state_next;

    logic       access;
    logic       aligned;
    logic       upper_zero;
    logic       in_range;
    logic       strb_ok;
    logic       legal;
    logic [4:0] idx;

    assign idx        = paddr_i[6:2];
    assign access     = psel_i & penable_i;
    assign aligned    = (paddr_i[1:0] == 2'b00);
    assign upper_zero = (paddr_i[PADDR_W-1:7] == '0);
    assign in_range   = (32'(idx) < NUM_REGS);
    assign strb_ok    = !pwrite_i || (pstrb_i == 4'hF);
    assign legal      = aligned & upper_zero & in_range & strb_ok;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            prdata_o <= '0;
        end else begin
            state <= state_next;
            // Capture on the single read-strobe cycle; illegal reads clear the data bus.
            if (state == IDLE && access && !pwrite_i) begin
                prdata_o <= legal ? reg_rdata_i : '0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        pready_o    = 1'b0;
        pslverr_o   = 1'b0;
        reg_we_o    = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
        reg_raddr_o = IDLE_RADDR;

        // Strobes are suppressed while reset is held so nothing reaches the register file.
        if (!reset_i) begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        if (!legal) begin
                            pready_o  = 1'b1;
                            pslverr_o = 1'b1;
                        end else if (pwrite_i) begin
                            reg_we_o    = 1'b1;
                            reg_waddr_o = idx;
                            reg_wdata_o = pwdata_i;
                            pready_o    = 1'b1;
                        end else begin
                            reg_raddr_o = idx;
                            state_next  = RD_RESP;
                        end
                    end
                end
                RD_RESP: begin
                    pready_o   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Self-checking bench for uart_apb_bridge: vector table, randomized transfers against a
// reference model, and hand-written back-to-back and reset sequences.
module tb_uart_apb_bridge;

    localparam int NUM_REGS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;

    always #5 clk = ~clk;

    uart_apb_bridge #(
        .PADDR_W   (12),
        .NUM_REGS  (NUM_REGS),
        .IDLE_RADDR(5'h1F)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .psel_i     (psel),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .paddr_i    (paddr),
        .pwdata_i   (pwdata),
        .pstrb_i    (pstrb),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .reg_we_o   (reg_we),
        .reg_waddr_o(reg_waddr),
        .reg_wdata_o(reg_wdata),
        .reg_raddr_o(reg_raddr),
        .reg_rdata_i(reg_rdata)
    );

    // UART register file stand-in: combinational read, write on strobe, pop/strobe counters.
    logic [31:0] mem [32];
    int          pop_cnt [32];
    int          we_cnt = 0;
    int          rs_cnt = 0;
    logic [4:0]  last_waddr;
    logic [31:0] last_wdata;
    logic [4:0]  last_raddr;
    logic        mon_on = 1'b0;

    assign reg_rdata = mem[reg_raddr];

    always @(posedge clk) begin
        if (reg_we) begin
            we_cnt++;
            last_waddr = reg_waddr;
            last_wdata = reg_wdata;
            mem[reg_waddr] <= reg_wdata;
        end
        if (reg_raddr != 5'h1F) begin
            rs_cnt++;
            pop_cnt[reg_raddr]++;
            last_raddr = reg_raddr;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !reg_we) check("wfields_zero_when_idle", {27'b0, reg_waddr} | reg_wdata, 32'h0);
    end

    // Reference model: register contents and the last value the read bus should show.
    logic [31:0] ref_mem [32];
    logic [31:0] ref_prdata = 32'h0;

    function automatic logic model_err(input logic wr, input int unsigned addr, input logic [3:0] strb);
        return (addr % 4 != 0) || (addr >= 4 * NUM_REGS) || (wr && strb != 4'hF);
    endfunction

    // Called at posedge+1; leaves the bus idle at posedge+1 so transfers can chain without gaps.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic exp_err, input int exp_cyc);
        int         cyc;
        int         we0;
        int         rs0;
        int         idx;
        logic       done;
        logic       got_err;
        logic [4:0] first_raddr;
        logic [4:0] exp_raddr;
        idx = int'(addr) / 4 % 32;
        we0 = we_cnt;
        rs0 = rs_cnt;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        check("setup_pready", {31'b0, pready}, 32'h0);
        check("setup_raddr", {27'b0, reg_raddr}, 32'h1F);
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; done = 1'b0; got_err = 1'b0; first_raddr = 5'h0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_raddr = reg_raddr;
            if (pready) begin
                done    = 1'b1;
                got_err = pslverr;
            end
        end
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("pslverr", {31'b0, got_err}, {31'b0, exp_err});
        exp_raddr = (!exp_err && !wr) ? 5'(idx) : 5'h1F;
        check("raddr_access", {27'b0, first_raddr}, {27'b0, exp_raddr});
        if (!exp_err && !wr) check("prdata_resp", prdata, ref_mem[idx]);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("we_pulses", 32'(we_cnt - we0), (!exp_err && wr) ? 32'd1 : 32'd0);
        check("rd_strobes", 32'(rs_cnt - rs0), (!exp_err && !wr) ? 32'd1 : 32'd0);
        if (!exp_err && wr) begin
            check("waddr", {27'b0, last_waddr}, 32'(idx));
            check("wdata", last_wdata, data);
            ref_mem[idx] = data;
        end
        if (!exp_err && !wr) check("raddr_index", {27'b0, last_raddr}, 32'(idx));
        if (!wr) ref_prdata = exp_err ? 32'h0 : ref_mem[idx];
        check("prdata_hold", prdata, ref_prdata);
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [11:0] addr;
        logic [3:0]  strb;
        logic        e;
        int          p1;

        for (int i = 0; i < 32; i++) begin
            mem[i]     = 32'h0000_00C0 + 32'(i);
            ref_mem[i] = 32'h0000_00C0 + 32'(i);
            pop_cnt[i] = 0;
        end
        vecs[0] = '{1'b1, 12'h008, 32'hA5A5_0001, 4'hF, 1'b0, 1};
        vecs[1] = '{1'b0, 12'h00C, 32'h0,         4'hF, 1'b0, 2};
        vecs[2] = '{1'b1, 12'h00A, 32'h1111_2222, 4'hF, 1'b1, 1};
        vecs[3] = '{1'b1, 12'h004, 32'h3333_4444, 4'h3, 1'b1, 1};
        vecs[4] = '{1'b0, 12'h020, 32'h0,         4'hF, 1'b1, 1};
        vecs[5] = '{1'b0, 12'h100, 32'h0,         4'hF, 1'b1, 1};
        vecs[6] = '{1'b0, 12'h008, 32'h0,         4'hF, 1'b0, 2};
        vecs[7] = '{1'b0, 12'h01C, 32'h0,         4'h0, 1'b0, 2};
        vecs[8] = '{1'b1, 12'h01C, 32'h1234_5678, 4'hF, 1'b0, 1};
        vecs[9] = '{1'b0, 12'h003, 32'h0,         4'hF, 1'b1, 1};

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_raddr", {27'b0, reg_raddr}, 32'h1F);
        check("rst_we", {31'b0, reg_we}, 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("idle_pready", {31'b0, pready}, 32'h0);
        @(posedge clk); #1;

        // Vector table; row 1 reads index 3, which the register file holds as 0xC3.
        for (int i = 0; i < 10; i++) begin
            if (i == 1) p1 = pop_cnt[3];
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_err, vecs[i].exp_cyc);
            if (i == 1) begin
                check("pop3_once", 32'(pop_cnt[3] - p1), 32'd1);
                check("read_c3", prdata, 32'h0000_00C3);
            end
        end

        // Randomized transfers checked against the reference model.
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    addr = 12'($urandom_range(0, NUM_REGS - 1) * 4);
                2:       addr = 12'($urandom_range(0, 4095));
                default: addr = 12'($urandom_range(0, 15) * 4);
            endcase
            strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            e = model_err(wr, 32'(addr), strb);
            xfer(wr, addr, $urandom, strb, e, (e || wr) ? 1 : 2);
        end

        // Back-to-back chain with only setup cycles between transfers.
        p1 = pop_cnt[1];
        xfer(1'b1, 12'h000, 32'hDEAD_0000, 4'hF, 1'b0, 1);
        xfer(1'b0, 12'h004, 32'h0,         4'hF, 1'b0, 2);
        xfer(1'b0, 12'h004, 32'h0,         4'hF, 1'b0, 2);
        xfer(1'b1, 12'h01C, 32'hBEEF_0007, 4'hF, 1'b0, 1);
        check("b2b_pop1", 32'(pop_cnt[1] - p1), 32'd2);

        // Reset in the RD_RESP cycle abandons the read; the next read completes normally.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("rdresp_rst_wait", {31'b0, pready}, 32'h0);
        @(posedge clk); #1;
        check("rdresp_rst_loaded", prdata, ref_mem[0]);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        ref_prdata = 32'h0;
        @(negedge clk);
        check("rdresp_rst_pready", {31'b0, pready}, 32'h0);
        check("rdresp_rst_prdata", prdata, 32'h0);
        @(posedge clk); #1;
        xfer(1'b0, 12'h000, 32'h0, 4'hF, 1'b0, 2);

        // Reset during an IDLE write access: no strobe may reach the register file.
        p1 = we_cnt;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("rst_access_we", {31'b0, reg_we}, 32'h0);
        check("rst_access_raddr", {27'b0, reg_raddr}, 32'h1F);
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        check("rst_access_we_cnt", 32'(we_cnt - p1), 32'd0);
        ref_prdata = 32'h0;
        xfer(1'b0, 12'h004, 32'h0, 4'hF, 1'b0, 2);

        mon_on = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

APB3 completer that sits directly upstream of the UART top level and converts APB transfers into the UART's single-cycle register-file port (`reg_we_i`, `reg_waddr_i`, `reg_wdata_i`, `reg_raddr_i`, `reg_rdata_o`).
- Writes complete with zero wait states.
- Reads take one wait state. The read address is presented for exactly one clock, so read-side-effect registers (RX data pop) fire exactly once per APB read.
- Misaligned, partial-strobe and out-of-range accesses return PSLVERR and never touch the register file.

## Interface
Parameters:
- `PADDR_W`, default 12: APB address width in bits (byte address).
- `NUM_REGS`, default 8: number of implemented word registers. Valid register index is 0..`NUM_REGS`-1.
- `IDLE_RADDR`, default 5'h1F: value driven on `reg_raddr_o` when no read is in progress. Must be ≥ `NUM_REGS`.

Ports:
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB enable (access phase).
- `pwrite_i`  in  1  1 = write, 0 = read.
- `paddr_i`  in  `PADDR_W`  byte address.
- `pwdata_i`  in  32  write data.
- `pstrb_i`  in  4  byte strobes. Only 4'hF is legal.
- `pready_o`  out  1  transfer complete.
- `prdata_o`  out  32  read data, registered.
- `pslverr_o`  out  1  error response, valid only while `pready_o`=1.
- `reg_we_o`  out  1  register write strobe, goes to UART `reg_we_i`.
- `reg_waddr_o`  out  5  write register index.
- `reg_wdata_o`  out  32  write data.
- `reg_raddr_o`  out  5  read register index, goes to UART `reg_raddr_i`.
- `reg_rdata_i`  in  32  read data from UART, combinational on `reg_raddr_o`.

## Operation
- Register index: `idx` = `paddr_i[6:2]`.
- Access is legal when all of the following hold:
  - `paddr_i[1:0]` == 0;
  - `paddr_i[PADDR_W-1:7]` == 0;
  - `idx` < `NUM_REGS`;
  - `pstrb_i` == 4'hF, for writes only (`pstrb_i` is ignored on reads).
- `access` = `psel_i` & `penable_i`. `pprot` is not supported or decoded.
- FSM states: IDLE and RD_RESP. The reset state is IDLE.
- IDLE, `access` and illegal:
  - `pready_o`=1, `pslverr_o`=1 combinationally.
  - No `reg_we_o` pulse; `reg_raddr_o` stays `IDLE_RADDR`.
  - State stays IDLE. On an illegal read, `prdata_o` is loaded with 0.
- IDLE, `access` and legal write:
  - `reg_we_o`=1, `reg_waddr_o`=`idx`, `reg_wdata_o`=`pwdata_i`, all combinational.
  - `pready_o`=1, `pslverr_o`=0. State stays IDLE.
- IDLE, `access` and legal read:
  - `reg_raddr_o`=`idx` combinationally; `pready_o`=0.
  - At the clock edge, `prdata_o` <= `reg_rdata_i` and the FSM moves to RD_RESP.
- RD_RESP:
  - `pready_o`=1, `pslverr_o`=0.
  - `reg_raddr_o`=`IDLE_RADDR`; `prdata_o` holds its value.
  - Next state is IDLE unconditionally.
- Setup phase (`psel_i`=1, `penable_i`=0) and idle bus (`psel_i`=0): no strobes, `pready_o`=0.
- `reg_waddr_o` and `reg_wdata_o` equal 0 whenever `reg_we_o`=0.

## Timing
- Reset values:
  - State IDLE.
  - `prdata_o`=0, `pready_o`=0, `pslverr_o`=0.
  - `reg_we_o`=0, `reg_waddr_o`=0, `reg_wdata_o`=0.
  - `reg_raddr_o`=`IDLE_RADDR`.
- Write latency: completes in the first access cycle, with zero wait states. `reg_we_o` is high for exactly 1 clock per write.
- Read latency: one wait state; `pready_o` rises in the second access cycle. `reg_raddr_o` ≠ `IDLE_RADDR` for exactly 1 clock per read.
- Error latency: zero wait states for both reads and writes.
- Back-to-back transfers: a setup cycle sits between transfers, so a read returns IDLE→RD_RESP→IDLE, then setup, then the next access. No extra idle cycle is required.
- Reset asserted during RD_RESP:
  - Next cycle is IDLE with `pready_o`=0 and `prdata_o`=0.
  - The pending transfer is abandoned, and the master restarts it.
- Reset asserted during an IDLE access: no `reg_we_o` or read strobe reaches the register file in that cycle.

## Test plan
- After reset, check outputs: `pready_o`=0, `prdata_o`=0, `reg_raddr_o`=5'h1F, `reg_we_o`=0.
- APB write to addr 0x008, data 0xA5A5_0001, strb F:
  - one-cycle `reg_we_o` with `reg_waddr_o`=2 and `reg_wdata_o`=0xA5A5_0001;
  - `pready_o`=1 in the first access cycle with `pslverr_o`=0.
- APB read of addr 0x00C with `reg_rdata_i` model returning 0x0000_00C3 for index 3:
  - `reg_raddr_o`=3 for exactly 1 clock;
  - `pready_o`=1 one cycle later with `prdata_o`=0x0000_00C3;
  - model pop counter increments by exactly 1.
- Illegal accesses each give `pready_o`=1, `pslverr_o`=1 in the first access cycle, no `reg_we_o` pulse and `reg_raddr_o` held at 0x1F:
  - write to 0x00A (misaligned);
  - write to 0x004 with strb 4'h3;
  - read of 0x020 (index 8 ≥ `NUM_REGS`), which also returns `prdata_o`=0;
  - read of 0x100 (upper address bits set).
- Back-to-back sequence write 0x000, read 0x004, read 0x004, write 0x01C: check the per-transfer strobe counts and latencies above; exactly two read strobes reach index 1.
- Assert `reset_i` in the RD_RESP cycle of a read: the next cycle shows IDLE, `pready_o`=0, `prdata_o`=0; a following read of 0x000 completes normally.
